fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction-memory request, fills the IF/ID register
// through a one-entry skid buffer, and redirects on taken branches and jumps from decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_id,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  op
);

  typedef enum logic [1:0] {StFetch, StFull, StKill} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;

  logic        redirect;
  logic        consume;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  // A redirect comes from the instruction sitting in IF/ID, so it only counts once decode takes it.
  assign consume         = valid_q & ~stall_id;
  assign redirect        = consume & (branch_taken | jump);
  assign redirect_target = branch_taken ? {branch_target[31:2], 2'b00}
                                        : {pc4_q[31:28], jump_index, 2'b00};
  assign pc_plus4        = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    target_d     = target_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    unique case (state_q)
      StFetch: begin
        if (redirect) begin
          valid_d = 1'b0;
          instr_d = 32'h0;
          if (imem_ready) begin
            pc_d = redirect_target;
          end else begin
            // Request is still outstanding; hold its address and drop the word when it lands.
            state_d  = StKill;
            target_d = redirect_target;
          end
        end else if (imem_ready) begin
          pc_d = pc_plus4;
          if (consume || !valid_q) begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_plus4;
            state_d      = StFull;
          end
        end else if (consume) begin
          valid_d = 1'b0;
          instr_d = 32'h0;
        end
      end
      StFull: begin
        if (redirect) begin
          valid_d = 1'b0;
          instr_d = 32'h0;
          pc_d    = redirect_target;
          state_d = StFetch;
        end else if (!stall_id) begin
          valid_d = 1'b1;
          instr_d = skid_instr_q;
          pc4_d   = skid_pc4_q;
          state_d = StFetch;
        end
      end
      StKill: begin
        if (imem_ready) begin
          pc_d    = target_q;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      target_q     <= RESET_PC;
      valid_q      <= 1'b0;
      instr_q      <= 32'h0;
      pc4_q        <= 32'h0;
      skid_instr_q <= 32'h0;
      skid_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      target_q     <= target_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  // Gated by reset so no request is seen while reset is held.
  assign imem_req    = ~reset & (state_q != StFull);
  assign imem_addr   = pc_q;
  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign op          = instr_q[31:26];

endmodule
